// File: rtl/conv_loop_sequencer_if.sv
// Handshake and address bus between the convolution loop sequencer and the MAC datapath.
// The sequencer side uses the master modport; datapath, memories and benches use slave.
interface conv_loop_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  rd_valid;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  pad_zero;
  logic [ADDR_WIDTH-1:0] wt_addr;
  logic [ADDR_WIDTH-1:0] bias_idx;
  logic                  mac_first;
  logic                  mac_last;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] out_addr;

  modport master (
    input  start, wr_ready,
    output busy, done, rd_valid, in_addr, pad_zero, wt_addr, bias_idx,
           mac_first, mac_last, wr_valid, out_addr
  );

  modport slave (
    output start, wr_ready,
    input  busy, done, rd_valid, in_addr, pad_zero, wt_addr, bias_idx,
           mac_first, mac_last, wr_valid, out_addr
  );
endinterface

// File: rtl/conv_loop_sequencer.sv
// Walks out_ch > out_h > out_w > in_ch > k_h > k_w, issuing one MAC tap per cycle and one
// output write per pixel. All outputs are registered from the next-state counters.
module conv_loop_sequencer #(
  parameter int unsigned OUT_CHANNELS = 4,
  parameter int unsigned IN_CHANNELS  = 3,
  parameter int unsigned IN_HEIGHT    = 8,
  parameter int unsigned IN_WIDTH     = 8,
  parameter int unsigned KERNEL_SIZE  = 3,
  parameter int unsigned STRIDE       = 1,
  parameter int unsigned PADDING      = 1,
  parameter int unsigned MAC_LAT      = 2,
  parameter int unsigned ADDR_WIDTH   = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  conv_loop_sequencer_if.master bus
);

  localparam int unsigned AW    = ADDR_WIDTH;
  localparam int unsigned OUT_H = (IN_HEIGHT + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
  localparam int unsigned OUT_W = (IN_WIDTH + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;

  typedef logic [AW-1:0]        cnt_t;
  typedef logic signed [AW:0]   scnt_t;

  localparam cnt_t OcMax   = cnt_t'(OUT_CHANNELS - 1);
  localparam cnt_t OhMax   = cnt_t'(OUT_H - 1);
  localparam cnt_t OwMax   = cnt_t'(OUT_W - 1);
  localparam cnt_t IcMax   = cnt_t'(IN_CHANNELS - 1);
  localparam cnt_t KMax    = cnt_t'(KERNEL_SIZE - 1);
  localparam cnt_t WaitMax = cnt_t'((MAC_LAT == 0) ? 0 : MAC_LAT - 1);
  localparam cnt_t One     = cnt_t'(1);
  localparam cnt_t Zero    = cnt_t'(0);
  localparam cnt_t InH     = cnt_t'(IN_HEIGHT);
  localparam cnt_t InW     = cnt_t'(IN_WIDTH);
  localparam cnt_t InC     = cnt_t'(IN_CHANNELS);
  localparam cnt_t Ksz     = cnt_t'(KERNEL_SIZE);
  localparam cnt_t OutH    = cnt_t'(OUT_H);
  localparam cnt_t OutW    = cnt_t'(OUT_W);
  localparam scnt_t StrideS = scnt_t'(STRIDE);
  localparam scnt_t PadS    = scnt_t'(PADDING);
  localparam scnt_t InHS    = scnt_t'(IN_HEIGHT);
  localparam scnt_t InWS    = scnt_t'(IN_WIDTH);

  typedef enum logic [2:0] {StIdle, StRun, StWait, StWrite, StDone} state_e;

  state_e state_q, state_d;
  cnt_t   oc_q, oh_q, ow_q, ic_q, kh_q, kw_q, wait_q;
  cnt_t   oc_d, oh_d, ow_d, ic_d, kh_d, kw_d, wait_d;

  logic busy_q, done_q, rd_valid_q, pad_zero_q, mac_first_q, mac_last_q, wr_valid_q;
  logic busy_d, done_d, rd_valid_d, pad_zero_d, mac_first_d, mac_last_d, wr_valid_d;
  cnt_t in_addr_q, wt_addr_q, bias_idx_q, out_addr_q;
  cnt_t in_addr_d, wt_addr_d, bias_idx_d, out_addr_d;

  logic  tap_last, pix_last, pad;
  scnt_t ih, iw;

  assign tap_last = (ic_q == IcMax) && (kh_q == KMax) && (kw_q == KMax);
  assign pix_last = (oc_q == OcMax) && (oh_q == OhMax) && (ow_q == OwMax);

  always_comb begin
    state_d = state_q;
    oc_d    = oc_q;
    oh_d    = oh_q;
    ow_d    = ow_q;
    ic_d    = ic_q;
    kh_d    = kh_q;
    kw_d    = kw_q;
    wait_d  = wait_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          oc_d = Zero; oh_d = Zero; ow_d = Zero;
          ic_d = Zero; kh_d = Zero; kw_d = Zero;
          wait_d = Zero;
        end
      end
      StRun: begin
        if (tap_last) begin
          ic_d    = Zero;
          kh_d    = Zero;
          kw_d    = Zero;
          wait_d  = Zero;
          state_d = (MAC_LAT > 0) ? StWait : StWrite;
        end else if (kw_q == KMax) begin
          kw_d = Zero;
          if (kh_q == KMax) begin
            kh_d = Zero;
            ic_d = ic_q + One;
          end else begin
            kh_d = kh_q + One;
          end
        end else begin
          kw_d = kw_q + One;
        end
      end
      StWait: begin
        if (wait_q == WaitMax) state_d = StWrite;
        else                   wait_d  = wait_q + One;
      end
      StWrite: begin
        if (bus.wr_ready) begin
          if (pix_last) begin
            state_d = StDone;
            oc_d = Zero; oh_d = Zero; ow_d = Zero;
          end else begin
            state_d = StRun;
            if (ow_q == OwMax) begin
              ow_d = Zero;
              if (oh_q == OhMax) begin
                oh_d = Zero;
                oc_d = oc_q + One;
              end else begin
                oh_d = oh_q + One;
              end
            end else begin
              ow_d = ow_q + One;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are derived from next-state values so the registered copies line up with the
  // state they describe.
  always_comb begin
    ih  = $signed({1'b0, oh_d}) * StrideS + $signed({1'b0, kh_d}) - PadS;
    iw  = $signed({1'b0, ow_d}) * StrideS + $signed({1'b0, kw_d}) - PadS;
    pad = ih[AW] | iw[AW] | (ih >= InHS) | (iw >= InWS);

    rd_valid_d  = (state_d == StRun);
    wr_valid_d  = (state_d == StWrite);
    done_d      = (state_d == StDone);
    busy_d      = (state_d == StRun) || (state_d == StWait) || (state_d == StWrite);
    pad_zero_d  = rd_valid_d & pad;
    mac_first_d = rd_valid_d && (ic_d == Zero) && (kh_d == Zero) && (kw_d == Zero);
    mac_last_d  = rd_valid_d && (ic_d == IcMax) && (kh_d == KMax) && (kw_d == KMax);

    in_addr_d   = Zero;
    wt_addr_d   = Zero;
    out_addr_d  = Zero;
    bias_idx_d  = Zero;
    if (rd_valid_d) begin
      if (!pad) in_addr_d = (ic_d * InH + ih[AW-1:0]) * InW + iw[AW-1:0];
      wt_addr_d = ((oc_d * InC + ic_d) * Ksz + kh_d) * Ksz + kw_d;
    end
    if (wr_valid_d) out_addr_d = (oc_d * OutH + oh_d) * OutW + ow_d;
    if (busy_d)     bias_idx_d = oc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      oc_q        <= Zero;
      oh_q        <= Zero;
      ow_q        <= Zero;
      ic_q        <= Zero;
      kh_q        <= Zero;
      kw_q        <= Zero;
      wait_q      <= Zero;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      pad_zero_q  <= 1'b0;
      mac_first_q <= 1'b0;
      mac_last_q  <= 1'b0;
      wr_valid_q  <= 1'b0;
      in_addr_q   <= Zero;
      wt_addr_q   <= Zero;
      bias_idx_q  <= Zero;
      out_addr_q  <= Zero;
    end else begin
      state_q     <= state_d;
      oc_q        <= oc_d;
      oh_q        <= oh_d;
      ow_q        <= ow_d;
      ic_q        <= ic_d;
      kh_q        <= kh_d;
      kw_q        <= kw_d;
      wait_q      <= wait_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_valid_q  <= rd_valid_d;
      pad_zero_q  <= pad_zero_d;
      mac_first_q <= mac_first_d;
      mac_last_q  <= mac_last_d;
      wr_valid_q  <= wr_valid_d;
      in_addr_q   <= in_addr_d;
      wt_addr_q   <= wt_addr_d;
      bias_idx_q  <= bias_idx_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.pad_zero  = pad_zero_q;
  assign bus.mac_first = mac_first_q;
  assign bus.mac_last  = mac_last_q;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.in_addr   = in_addr_q;
  assign bus.wt_addr   = wt_addr_q;
  assign bus.bias_idx  = bias_idx_q;
  assign bus.out_addr  = out_addr_q;

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Directed bench: default 4x3x8x8 k3 s1 p1 sequencer plus a stride-2, no-padding instance.
module tb_conv_loop_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  conv_loop_sequencer_if #(.ADDR_WIDTH(16)) bus0 ();
  conv_loop_sequencer_if #(.ADDR_WIDTH(16)) bus1 ();

  conv_loop_sequencer dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  conv_loop_sequencer #(
    .STRIDE  (2),
    .PADDING (0)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one pass to its done pulse, sampling every falling edge; performs no comparisons.
  task automatic drain(input bit sel, input int first_addr, output int writes,
                       output int bad_order, output int pads, output int addr2,
                       output int cycles, output bit timeout);
    logic        wv, wr, dn, rv, pz, mf;
    logic [15:0] oa, ia;
    int          firsts;
    writes = 0; bad_order = 0; pads = 0; addr2 = -1; cycles = 0; timeout = 1'b1; firsts = 0;
    for (int c = 0; c < 10000; c++) begin
      if (sel) begin
        wv = bus1.wr_valid; wr = bus1.wr_ready; dn = bus1.done; rv = bus1.rd_valid;
        pz = bus1.pad_zero; mf = bus1.mac_first; oa = bus1.out_addr; ia = bus1.in_addr;
      end else begin
        wv = bus0.wr_valid; wr = bus0.wr_ready; dn = bus0.done; rv = bus0.rd_valid;
        pz = bus0.pad_zero; mf = bus0.mac_first; oa = bus0.out_addr; ia = bus0.in_addr;
      end
      if (rv && mf) begin
        firsts++;
        if (firsts == 2) addr2 = int'(ia);
      end
      if (pz) pads++;
      if (wv && wr) begin
        if (int'(oa) != first_addr + writes) bad_order++;
        writes++;
      end
      if (dn === 1'b1) begin
        cycles  = c;
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus0.start = 1'b0; bus0.wr_ready = 1'b1;
    bus1.start = 1'b0; bus1.wr_ready = 1'b1;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus0.busy, bus0.done, bus0.rd_valid, bus0.wr_valid, bus0.pad_zero, bus0.mac_first,
         bus0.mac_last} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 0000000", {bus0.busy, bus0.done, bus0.rd_valid,
               bus0.wr_valid, bus0.pad_zero, bus0.mac_first, bus0.mac_last});
    end
    checks++;
    if ({bus0.in_addr, bus0.wt_addr, bus0.bias_idx, bus0.out_addr} !== 64'b0) begin
      failures++;
      $display("FAIL reset_addrs: got %h want 0", {bus0.in_addr, bus0.wt_addr, bus0.bias_idx,
               bus0.out_addr});
    end
    checks++;
    if ({bus1.busy, bus1.rd_valid, bus1.wr_valid} !== 3'b0) begin
      failures++;
      $display("FAIL reset_dut1: got %b want 000", {bus1.busy, bus1.rd_valid, bus1.wr_valid});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus0.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_start: busy got %b want 0", bus0.busy);
    end
  endtask

  task automatic test_full_pass();
    int w, bad, pads, a2, cyc;
    bit to;
    @(negedge clk); bus0.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0;
    checks++;
    if ({bus0.busy, bus0.rd_valid, bus0.mac_first} !== 3'b111) begin
      failures++;
      $display("FAIL t1_run_entry: got %b want 111", {bus0.busy, bus0.rd_valid, bus0.mac_first});
    end
    drain(1'b0, 0, w, bad, pads, a2, cyc, to);
    checks++;
    if (to) begin failures++; $display("FAIL t1_timeout: done never seen"); end
    checks++;
    if (w != 256) begin failures++; $display("FAIL t1_writes: got %0d want 256", w); end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL t1_order: got %0d bad want 0", bad); end
    checks++;
    if (cyc != 7680) begin failures++; $display("FAIL t1_cycles: got %0d want 7680", cyc); end
    @(negedge clk);
    checks++;
    if ({bus0.done, bus0.busy} !== 2'b00) begin
      failures++;
      $display("FAIL t1_after_done: got %b want 00", {bus0.done, bus0.busy});
    end
  endtask

  task automatic test_pixel0();
    int ic, kh, kw, ih, iw, w, bad, pads, a2, cyc;
    bit pad, to;
    logic [15:0] e_in;
    @(negedge clk); bus0.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0;
    for (int t = 0; t < 27; t++) begin
      ic = t / 9; kh = (t % 9) / 3; kw = t % 3;
      ih = kh - 1; iw = kw - 1;
      pad  = (ih < 0) || (iw < 0);
      e_in = pad ? 16'd0 : 16'((ic * 8 + ih) * 8 + iw);
      checks++;
      if ({bus0.rd_valid, bus0.pad_zero} !== {1'b1, pad}) begin
        failures++;
        $display("FAIL t2_pad tap%0d: got %b want %b", t, {bus0.rd_valid, bus0.pad_zero},
                 {1'b1, pad});
      end
      checks++;
      if (bus0.in_addr !== e_in) begin
        failures++;
        $display("FAIL t2_in_addr tap%0d: got %0d want %0d", t, bus0.in_addr, e_in);
      end
      checks++;
      if (bus0.wt_addr !== 16'(t)) begin
        failures++;
        $display("FAIL t2_wt_addr tap%0d: got %0d want %0d", t, bus0.wt_addr, t);
      end
      checks++;
      if ({bus0.mac_first, bus0.mac_last} !== {t == 0, t == 26}) begin
        failures++;
        $display("FAIL t2_first_last tap%0d: got %b want %b", t,
                 {bus0.mac_first, bus0.mac_last}, {t == 0, t == 26});
      end
      @(negedge clk);
    end
    repeat (2) begin
      checks++;
      if ({bus0.rd_valid, bus0.wr_valid} !== 2'b00) begin
        failures++;
        $display("FAIL t2_wait: got %b want 00", {bus0.rd_valid, bus0.wr_valid});
      end
      @(negedge clk);
    end
    checks++;
    if ({bus0.wr_valid, bus0.out_addr} !== {1'b1, 16'd0}) begin
      failures++;
      $display("FAIL t2_write: got %b/%0d want 1/0", bus0.wr_valid, bus0.out_addr);
    end
    drain(1'b0, 0, w, bad, pads, a2, cyc, to);
    checks++;
    if (to || w != 256 || bad != 0) begin
      failures++;
      $display("FAIL t2_rest: got to=%0d writes=%0d bad=%0d want 0/256/0", to, w, bad);
    end
  endtask

  task automatic test_write_stall();
    int n, w, bad, pads, a2, cyc;
    bit to;
    bus0.wr_ready = 1'b0;
    @(negedge clk); bus0.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0;
    n = 0;
    while (n < 100 && bus0.wr_valid !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 29) begin failures++; $display("FAIL t3_first_write: got cycle %0d want 29", n); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({bus0.wr_valid, bus0.rd_valid, bus0.out_addr} !== {2'b10, 16'd0}) begin
        failures++;
        $display("FAIL t3_hold cyc%0d: got wv=%b rv=%b oa=%0d want 1/0/0", i, bus0.wr_valid,
                 bus0.rd_valid, bus0.out_addr);
      end
      if (i == 5) bus0.wr_ready = 1'b1;
      @(negedge clk);
    end
    checks++;
    if ({bus0.wr_valid, bus0.rd_valid, bus0.mac_first} !== 3'b011) begin
      failures++;
      $display("FAIL t3_resume: got %b want 011", {bus0.wr_valid, bus0.rd_valid,
               bus0.mac_first});
    end
    drain(1'b0, 1, w, bad, pads, a2, cyc, to);
    checks++;
    if (to || w != 255 || bad != 0 || cyc != 7650) begin
      failures++;
      $display("FAIL t3_rest: got to=%0d writes=%0d bad=%0d cyc=%0d want 0/255/0/7650",
               to, w, bad, cyc);
    end
  endtask

  task automatic test_stride2();
    int w, bad, pads, a2, cyc;
    bit to;
    @(negedge clk); bus1.start = 1'b1;
    @(negedge clk); bus1.start = 1'b0;
    drain(1'b1, 0, w, bad, pads, a2, cyc, to);
    checks++;
    if (to || w != 36 || bad != 0) begin
      failures++;
      $display("FAIL t4_writes: got to=%0d writes=%0d bad=%0d want 0/36/0", to, w, bad);
    end
    checks++;
    if (pads != 0) begin failures++; $display("FAIL t4_pad: got %0d want 0", pads); end
    checks++;
    if (a2 != 2) begin failures++; $display("FAIL t4_ow1_tap0: got %0d want 2", a2); end
    checks++;
    if (cyc != 1080) begin failures++; $display("FAIL t4_cycles: got %0d want 1080", cyc); end
  endtask

  task automatic test_reset_mid();
    int w, bad, pads, a2, cyc;
    bit to;
    @(negedge clk); bus0.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0;
    repeat (160) @(negedge clk);
    checks++;
    if ({bus0.rd_valid, bus0.wt_addr} !== {1'b1, 16'd10}) begin
      failures++;
      $display("FAIL t5_tap10: got rv=%b wt=%0d want 1/10", bus0.rd_valid, bus0.wt_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus0.busy, bus0.rd_valid, bus0.wr_valid, bus0.mac_first, bus0.pad_zero,
         bus0.in_addr, bus0.wt_addr, bus0.bias_idx, bus0.out_addr} !== 69'b0) begin
      failures++;
      $display("FAIL t5_async_clear: got busy=%b rv=%b wv=%b in=%0d wt=%0d", bus0.busy,
               bus0.rd_valid, bus0.wr_valid, bus0.in_addr, bus0.wt_addr);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus0.busy, bus0.rd_valid, bus0.wr_valid} !== 3'b000) begin
      failures++;
      $display("FAIL t5_stay_idle: got %b want 000", {bus0.busy, bus0.rd_valid,
               bus0.wr_valid});
    end
    bus0.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0;
    drain(1'b0, 0, w, bad, pads, a2, cyc, to);
    checks++;
    if (to || w != 256 || bad != 0 || cyc != 7680) begin
      failures++;
      $display("FAIL t5_restart: got to=%0d writes=%0d bad=%0d cyc=%0d want 0/256/0/7680",
               to, w, bad, cyc);
    end
  endtask

  task automatic test_start_held();
    int w, bad, pads, a2, cyc;
    bit to;
    @(negedge clk); bus0.start = 1'b1;
    @(negedge clk);
    drain(1'b0, 0, w, bad, pads, a2, cyc, to);
    checks++;
    if (to || w != 256 || cyc != 7680) begin
      failures++;
      $display("FAIL t6_pass: got to=%0d writes=%0d cyc=%0d want 0/256/7680", to, w, cyc);
    end
    checks++;
    if (bus0.busy !== 1'b0) begin
      failures++;
      $display("FAIL t6_busy_in_done: got %b want 0", bus0.busy);
    end
    @(negedge clk);
    checks++;
    if ({bus0.done, bus0.busy, bus0.rd_valid} !== 3'b000) begin
      failures++;
      $display("FAIL t6_idle_after_done: got %b want 000", {bus0.done, bus0.busy,
               bus0.rd_valid});
    end
    @(negedge clk);
    checks++;
    if ({bus0.busy, bus0.rd_valid, bus0.out_addr} !== {2'b11, 16'd0}) begin
      failures++;
      $display("FAIL t6_second_pass: got busy=%b rv=%b want 1/1", bus0.busy, bus0.rd_valid);
    end
    bus0.start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_full_pass();
    test_pixel0();
    test_write_stall();
    test_stride2();
    test_reset_mid();
    test_start_held();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
